alu_arbiter: RTL and testbench

- Shares the single 64-bit combinational ALU between two requesters: the execute-stage integer path (port 0) and the address-generation/branch-compare path (port 1).
- Uses valid/ready handshakes with round-robin grant and a registered one-entry response slot with backpressure.
- Maintains the architectural NZCV flag register, updated by flag-setting operations.
- Sits between the pipeline's execute logic and the alu instance.

---
 rtl/alu_pkg.sv | 44 ++++
 rtl/rr_arb2.sv | 42 ++++
 rtl/alu_arbiter.sv | 152 +++++++++++++++
 tb/tb_alu_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcode, flag-index and opcode-class definitions
//
// Contents:
//   ALU_* opcode constants (3-bit alu_cntrl encodings)
//   FLAG_* bit positions inside a {N,Z,C,V} flag vector
//   flags_t       packed {n,z,c,v} view of a flag vector
//   is_legal_op   opcode is one the ALU implements
//   is_arith_op   opcode produces meaningful carry/overflow
package alu_pkg;

    localparam logic [2:0] ALU_PASS_B   = 3'b000;
    localparam logic [2:0] ALU_ADD      = 3'b010;
    localparam logic [2:0] ALU_SUBTRACT = 3'b011;
    localparam logic [2:0] ALU_AND      = 3'b100;
    localparam logic [2:0] ALU_OR       = 3'b101;
    localparam logic [2:0] ALU_XOR      = 3'b110;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    function automatic logic is_legal_op(input logic [2:0] cntrl);
        logic legal;
        case (cntrl)
            ALU_PASS_B, ALU_ADD, ALU_SUBTRACT,
            ALU_AND, ALU_OR, ALU_XOR: legal = 1'b1;
            default:                  legal = 1'b0;
        endcase
        return legal;
    endfunction

    function automatic logic is_arith_op(input logic [2:0] cntrl);
        return (cntrl == ALU_ADD) || (cntrl == ALU_SUBTRACT);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter with registered priority pointer
//
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   valid[1:0]     per-requester request
//   enable         grants may be issued this cycle
//   grant[1:0]     one-hot (or zero) combinational grant
module rr_arb2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] valid,
    input  logic       enable,
    output logic [1:0] grant
);

    // ptr names the side that wins when both request.
    logic ptr;

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = ptr ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    // The side just served loses priority; idle cycles keep the pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= 1'b0;
        end else if (grant[0]) begin
            ptr <= 1'b1;
        end else if (grant[1]) begin
            ptr <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one combinational ALU between two requesters, keeps NZCV
//
// Optional feature macro: ALU_ARB_PERF_EN (saturating grant/conflict counters).
//
// Ports:
//   clk, reset_n                       clock, asynchronous active-low reset
//   reqN_valid/ready/a/b/cntrl/setflags  requester N operation handshake
//   alu_a, alu_b, alu_cntrl            operands/opcode to the ALU
//   alu_result, alu_negative, alu_zero,
//   alu_overflow, alu_carry_out        ALU outputs (same cycle)
//   rsp_valid/ready/id/result/flags/err  one-entry registered response slot
//   nzcv                               architectural flag register {N,Z,C,V}
//   perf_grant0/1, perf_conflict       performance counters (0 without the macro)
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_cntrl,
    input  logic             req0_setflags,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_cntrl,
    input  logic             req1_setflags,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_cntrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_negative,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    input  logic             alu_carry_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_flags,
    output logic             rsp_err,
    output logic [3:0]       nzcv,
    output logic [CNT_W-1:0] perf_grant0,
    output logic [CNT_W-1:0] perf_grant1,
    output logic [CNT_W-1:0] perf_conflict
);

    logic       can_accept;
    logic [1:0] grant;
    logic       any_grant;
    logic       sel_setflags;
    logic [3:0] cur_flags;

    // Slot is free, or the consumer empties it on this same edge.
    assign can_accept = !rsp_valid || rsp_ready;

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .reset_n (reset_n),
        .valid   ({req1_valid, req0_valid}),
        .enable  (can_accept),
        .grant   (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign any_grant  = grant[0] || grant[1];

    always_comb begin
        alu_a        = '0;
        alu_b        = '0;
        alu_cntrl    = ALU_PASS_B;
        sel_setflags = 1'b0;
        if (grant[0]) begin
            alu_a        = req0_a;
            alu_b        = req0_b;
            alu_cntrl    = req0_cntrl;
            sel_setflags = req0_setflags;
        end else if (grant[1]) begin
            alu_a        = req1_a;
            alu_b        = req1_b;
            alu_cntrl    = req1_cntrl;
            sel_setflags = req1_setflags;
        end
    end

    // Carry/overflow only mean something for add/subtract; mask them otherwise.
    always_comb begin
        cur_flags         = '0;
        cur_flags[FLAG_N] = alu_negative;
        cur_flags[FLAG_Z] = alu_zero;
        if (is_arith_op(alu_cntrl)) begin
            cur_flags[FLAG_C] = alu_carry_out;
            cur_flags[FLAG_V] = alu_overflow;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            rsp_err    <= 1'b0;
            nzcv       <= '0;
        end else if (any_grant) begin
            rsp_valid  <= 1'b1;
            rsp_id     <= grant[1];
            rsp_result <= alu_result;
            rsp_flags  <= cur_flags;
            rsp_err    <= !is_legal_op(alu_cntrl);
            if (sel_setflags && is_legal_op(alu_cntrl)) begin
                nzcv <= cur_flags;
            end
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

`ifdef ALU_ARB_PERF_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_grant0   <= '0;
            perf_grant1   <= '0;
            perf_conflict <= '0;
        end else begin
            if (grant[0] && perf_grant0 != CNT_MAX) begin
                perf_grant0 <= perf_grant0 + 1'b1;
            end
            if (grant[1] && perf_grant1 != CNT_MAX) begin
                perf_grant1 <= perf_grant1 + 1'b1;
            end
            if (req0_valid && req1_valid && perf_conflict != CNT_MAX) begin
                perf_conflict <= perf_conflict + 1'b1;
            end
        end
    end
`else
    assign perf_grant0   = '0;
    assign perf_grant1   = '0;
    assign perf_conflict = '0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter with a behavioural ALU
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int W  = 64;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req0_valid, req1_valid, req0_ready, req1_ready;
    logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
    logic [2:0]    req0_cntrl, req1_cntrl;
    logic          req0_setflags, req1_setflags;
    logic [W-1:0]  alu_a, alu_b, alu_result;
    logic [2:0]    alu_cntrl;
    logic          alu_negative, alu_zero, alu_overflow, alu_carry_out;
    logic          rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [W-1:0]  rsp_result;
    logic [3:0]    rsp_flags, nzcv;
    logic [CW-1:0] perf_grant0, perf_grant1, perf_conflict;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_cntrl(req0_cntrl), .req0_setflags(req0_setflags),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_cntrl(req1_cntrl), .req1_setflags(req1_setflags),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cntrl(alu_cntrl), .alu_result(alu_result),
        .alu_negative(alu_negative), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .alu_carry_out(alu_carry_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_flags(rsp_flags), .rsp_err(rsp_err), .nzcv(nzcv),
        .perf_grant0(perf_grant0), .perf_grant1(perf_grant1), .perf_conflict(perf_conflict)
    );

    // Behavioural ALU; illegal opcodes return ~b so pass-through is visible.
    logic [W:0] sum;
    always_comb begin
        sum           = '0;
        alu_result    = ~alu_b;
        alu_carry_out = 1'b0;
        alu_overflow  = 1'b0;
        case (alu_cntrl)
            ALU_PASS_B: alu_result = alu_b;
            ALU_ADD: begin
                sum           = {1'b0, alu_a} + {1'b0, alu_b};
                alu_result    = sum[W-1:0];
                alu_carry_out = sum[W];
                alu_overflow  = (alu_a[W-1] == alu_b[W-1]) && (sum[W-1] != alu_a[W-1]);
            end
            ALU_SUBTRACT: begin
                sum           = {1'b0, alu_a} + {1'b0, ~alu_b} + 65'd1;
                alu_result    = sum[W-1:0];
                alu_carry_out = sum[W];
                alu_overflow  = (alu_a[W-1] != alu_b[W-1]) && (sum[W-1] != alu_a[W-1]);
            end
            ALU_AND: alu_result = alu_a & alu_b;
            ALU_OR:  alu_result = alu_a | alu_b;
            ALU_XOR: alu_result = alu_a ^ alu_b;
            default: alu_result = ~alu_b;
        endcase
        alu_negative = alu_result[W-1];
        alu_zero     = (alu_result == '0);
    end

    typedef struct {
        logic [W-1:0] a, b;
        logic [2:0]   c;
        logic         s;
        logic [W-1:0] res;
        logic [3:0]   fl;
        logic         err;
        logic [3:0]   nz;
    } op_t;

    typedef struct {
        logic         id;
        logic [W-1:0] res;
        logic [3:0]   fl;
        logic         err;
        logic [3:0]   nz;
    } exp_t;

    op_t  ops[11];
    exp_t sb[$];
    exp_t e;
    int   n_vec = 0;
    int   n_err = 0;
    int   exp_g0 = 0, exp_g1 = 0, exp_cf = 0;

    function automatic op_t mk(logic [W-1:0] a, logic [W-1:0] b, logic [2:0] c, logic s,
                               logic [W-1:0] res, logic [3:0] fl, logic err, logic [3:0] nz);
        op_t o;
        o.a = a; o.b = b; o.c = c; o.s = s;
        o.res = res; o.fl = fl; o.err = err; o.nz = nz;
        return o;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    // One clock of directed stimulus. g: expected grant (0 none, 1 port0, 2 port1);
    // rv: expected rsp_valid during this cycle.
    task automatic run_row(input logic v0, input int o0, input logic v1, input int o1,
                           input logic rr, input int g, input logic rv);
        exp_t x;
        @(posedge clk);
        #1;
        req0_valid = v0; req0_a = v0 ? ops[o0].a : '0; req0_b = v0 ? ops[o0].b : '0;
        req0_cntrl = v0 ? ops[o0].c : 3'b000; req0_setflags = v0 ? ops[o0].s : 1'b0;
        req1_valid = v1; req1_a = v1 ? ops[o1].a : '0; req1_b = v1 ? ops[o1].b : '0;
        req1_cntrl = v1 ? ops[o1].c : 3'b000; req1_setflags = v1 ? ops[o1].s : 1'b0;
        rsp_ready  = rr;
        @(negedge clk);
        check("req0_ready", W'(req0_ready), W'(g == 1));
        check("req1_ready", W'(req1_ready), W'(g == 2));
        check("rsp_valid", W'(rsp_valid), W'(rv));
        if (g != 0) begin
            int oi;
            oi    = (g == 1) ? o0 : o1;
            x.id  = (g == 2);
            x.res = ops[oi].res; x.fl = ops[oi].fl; x.err = ops[oi].err; x.nz = ops[oi].nz;
            sb.push_back(x);
        end
        if (g == 1) exp_g0++;
        if (g == 2) exp_g1++;
        if (v0 && v1) exp_cf++;
    endtask

    task automatic check_perf(input string tag);
`ifdef ALU_ARB_PERF_EN
        check({tag, "_perf_grant0"}, W'(perf_grant0), W'(exp_g0));
        check({tag, "_perf_grant1"}, W'(perf_grant1), W'(exp_g1));
        check({tag, "_perf_conflict"}, W'(perf_conflict), W'(exp_cf));
`else
        check({tag, "_perf_grant0"}, W'(perf_grant0), '0);
        check({tag, "_perf_grant1"}, W'(perf_grant1), '0);
        check({tag, "_perf_conflict"}, W'(perf_conflict), '0);
`endif
    endtask

    localparam int NONE = 0, A = 1, B = 2, C = 3, D = 4, E = 5, F = 6, G = 7, H = 8, I = 9, J = 10;

    initial begin
        ops[0]  = mk('0, '0, ALU_PASS_B, 1'b0, '0, 4'b0000, 1'b0, 4'b0000);
        ops[A]  = mk(64'd2, 64'd3, ALU_ADD, 1'b0, 64'd5, 4'b0000, 1'b0, 4'b0000);
        ops[B]  = mk(64'hA0, 64'h0B, ALU_OR, 1'b0, 64'hAB, 4'b0000, 1'b0, 4'b0000);
        ops[C]  = mk(64'hFF, 64'hFF, ALU_XOR, 1'b0, 64'h0, 4'b0100, 1'b0, 4'b0000);
        ops[D]  = mk(64'h0, 64'h8000_0000_0000_0000, ALU_PASS_B, 1'b0,
                     64'h8000_0000_0000_0000, 4'b1000, 1'b0, 4'b0000);
        ops[E]  = mk(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, ALU_ADD, 1'b1,
                     64'h8000_0000_0000_0000, 4'b1001, 1'b0, 4'b1001);
        ops[F]  = mk(64'd5, 64'd5, ALU_SUBTRACT, 1'b0, 64'h0, 4'b0110, 1'b0, 4'b1001);
        ops[G]  = mk(64'hF0, 64'h0F, ALU_AND, 1'b0, 64'h0, 4'b0100, 1'b0, 4'b1001);
        ops[H]  = mk(64'hF0, 64'h0F, ALU_AND, 1'b1, 64'h0, 4'b0100, 1'b0, 4'b0100);
        ops[I]  = mk(64'h0, 64'h1234, 3'b111, 1'b1, 64'hFFFF_FFFF_FFFF_EDCB, 4'b1000, 1'b1, 4'b0100);
        ops[J]  = mk(64'd3, 64'd5, ALU_SUBTRACT, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, 1'b0, 4'b1000);

        req0_valid = 0; req0_a = '0; req0_b = '0; req0_cntrl = 3'b000; req0_setflags = 0;
        req1_valid = 0; req1_a = '0; req1_b = '0; req1_cntrl = 3'b000; req1_setflags = 0;
        rsp_ready = 0;

        // Scoreboard monitor: compares the slot against the queue head while valid,
        // pops when the consumer takes it.
        fork
            forever begin
                @(negedge clk);
                if (rsp_valid) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL rsp_unexpected: got response id %0d with empty scoreboard", rsp_id);
                    end else begin
                        e = sb[0];
                        check("rsp_id", W'(rsp_id), W'(e.id));
                        check("rsp_result", rsp_result, e.res);
                        check("rsp_flags", W'(rsp_flags), W'(e.fl));
                        check("rsp_err", W'(rsp_err), W'(e.err));
                        check("nzcv", W'(nzcv), W'(e.nz));
                        if (rsp_ready) void'(sb.pop_front());
                    end
                end
            end
        join_none

        repeat (2) @(posedge clk);
        #1;
        check("reset_rsp_valid", W'(rsp_valid), '0);
        check("reset_rsp_id", W'(rsp_id), '0);
        check("reset_rsp_result", rsp_result, '0);
        check("reset_rsp_flags", W'(rsp_flags), '0);
        check("reset_rsp_err", W'(rsp_err), '0);
        check("reset_nzcv", W'(nzcv), '0);
        check_perf("reset");
        reset_n = 1'b1;

        // Round robin from reset pointer: 0,1,0,1
        run_row(1, A, 1, B, 1, 1, 0);
        run_row(1, C, 1, B, 1, 2, 1);
        run_row(1, C, 1, D, 1, 1, 1);
        run_row(1, E, 1, D, 1, 2, 1);
        // Flag-setting add, then SUB 5-5 fills the slot
        run_row(1, E, 0, NONE, 1, 1, 1);
        run_row(0, NONE, 1, F, 1, 2, 1);
        // Backpressure: three held cycles, req0 waits
        run_row(0, NONE, 0, NONE, 0, 0, 1);
        run_row(1, G, 0, NONE, 0, 0, 1);
        run_row(1, G, 0, NONE, 0, 0, 1);
        // Release: drain and grant on the same edge
        run_row(1, G, 0, NONE, 1, 1, 1);
        run_row(1, H, 0, NONE, 1, 1, 1);
        // Illegal opcode on port 1
        run_row(0, NONE, 1, I, 1, 2, 1);
        // Drain to empty
        run_row(0, NONE, 0, NONE, 1, 0, 1);
        run_row(0, NONE, 0, NONE, 1, 0, 0);
        // Pending response about to be discarded by reset
        run_row(1, J, 0, NONE, 0, 1, 0);
        run_row(0, NONE, 0, NONE, 0, 0, 1);

        @(posedge clk);
        #1;
        check_perf("pre_reset");
        req0_valid = 0; req1_valid = 0; rsp_ready = 0;
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_rsp_valid", W'(rsp_valid), '0);
        check("async_reset_nzcv", W'(nzcv), '0);
        sb.delete();
        exp_g0 = 0; exp_g1 = 0; exp_cf = 0;
        check_perf("async_reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Pointer was 1 before reset; reset must restore port-0 priority.
        run_row(1, A, 1, B, 1, 1, 0);
        run_row(0, NONE, 0, NONE, 1, 0, 1);
        run_row(0, NONE, 0, NONE, 1, 0, 0);

        @(posedge clk);
        #1;
        check_perf("final");
        check("scoreboard_empty", W'(sb.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
